// File: rtl/ifetch_pkg.sv
// Shared types for the instruction-fetch memory path.
// Holds the responder FSM encoding and the fault data word.
package ifetch_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESPOND
  } imem_state_t;

  localparam logic [31:0] IMEM_FAULT_DATA = 32'h0;

endpackage

// File: rtl/imem_array.sv
// Single-clock instruction RAM: one sync write port, one sync read port.
// Read register clears on reset so the response path starts at zero.
module imem_array #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned AW = $clog2(DEPTH_WORDS)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [31:0]   wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/inst_mem_responder.sv
// Fetch-side responder: captures a word request, waits, then holds the
// response while the same address stays presented.
module inst_mem_responder
  import ifetch_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] mem_fetch_addr,
  input  logic        mem_fetch_addr_en,
  output logic [31:0] mem_inst_in,
  output logic        mem_inst_valid,
  output logic        mem_inst_access_fault,
  input  logic [31:0] load_addr,
  input  logic [31:0] load_data,
  input  logic        load_en
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);
  localparam int unsigned CW =
    (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;
  localparam logic [32:0] SPAN = 33'(DEPTH_WORDS) << 2;

  imem_state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [31:0]   cap_addr, cap_addr_n;
  logic          fault;
  logic          capture;
  logic          rd_en;
  logic [31:0]   fetch_off;
  logic [31:0]   load_off;
  logic          fetch_ok;
  logic          load_ok;
  logic          same;
  logic [31:0]   arr_rdata;

  assign fetch_off = mem_fetch_addr - BASE_ADDR;
  assign load_off  = load_addr - BASE_ADDR;
  assign fetch_ok  = (mem_fetch_addr >= BASE_ADDR) &&
                     ({1'b0, fetch_off} < SPAN);
  assign load_ok   = (load_addr >= BASE_ADDR) &&
                     ({1'b0, load_off} < SPAN);
  assign same      = (mem_fetch_addr == cap_addr);

  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    cap_addr_n = cap_addr;
    capture    = 1'b0;
    rd_en      = 1'b0;
    unique case (state)
      IDLE: begin
        if (mem_fetch_addr_en && !load_en) capture = 1'b1;
      end
      WAIT: begin
        if (load_en || !mem_fetch_addr_en || !same) begin
          state_n = IDLE;
        end else begin
          cnt_n = cnt - 1'b1;
          if (cnt == CW'(1)) begin
            state_n = RESPOND;
            rd_en   = 1'b1;
          end
        end
      end
      RESPOND: begin
        if (load_en) state_n = IDLE;
        else if (mem_fetch_addr_en && same) state_n = RESPOND;
        else if (mem_fetch_addr_en) capture = 1'b1;
        else state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
    // A redirect out of RESPOND recaptures without an IDLE bubble
    if (capture) begin
      cap_addr_n = mem_fetch_addr;
      cnt_n      = CW'(WAIT_STATES);
      if (WAIT_STATES == 0) begin
        state_n = RESPOND;
        rd_en   = 1'b1;
      end else begin
        state_n = WAIT;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      cap_addr <= '0;
      fault    <= 1'b0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      cap_addr <= cap_addr_n;
      if (rd_en) fault <= !fetch_ok;
    end
  end

  imem_array #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .AW         (AW)
  ) u_array (
    .clk  (clk),
    .reset(reset),
    .we   (load_en && load_ok),
    .waddr(load_off[AW+1:2]),
    .wdata(load_data),
    .re   (rd_en && fetch_ok),
    .raddr(fetch_off[AW+1:2]),
    .rdata(arr_rdata)
  );

  assign mem_inst_in           = fault ? IMEM_FAULT_DATA : arr_rdata;
  assign mem_inst_access_fault = fault;
  assign mem_inst_valid        = (state == RESPOND) && mem_fetch_addr_en &&
                                 same && !load_en;

endmodule

// File: tb/tb_inst_mem_responder.sv
// Directed bench: three responders (W=0, W=3, BASE=0x100) on shared
// inputs, scoreboard of expected responses checked on the falling edge.
module tb_inst_mem_responder;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] fa = '0;
  logic        en = 1'b0;
  logic [31:0] la = '0;
  logic [31:0] ld = '0;
  logic        le = 1'b0;
  logic [2:0]  v;
  logic [2:0]  ff;
  logic [31:0] dd [3];

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  typedef struct {
    int          sel;
    logic [31:0] data;
    logic        fault;
    int          lat;
  } exp_t;
  exp_t q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  inst_mem_responder #(
    .DEPTH_WORDS(1024), .BASE_ADDR(32'h0), .WAIT_STATES(0)
  ) dut0 (
    .clk(clk), .reset(reset),
    .mem_fetch_addr(fa), .mem_fetch_addr_en(en),
    .mem_inst_in(dd[0]), .mem_inst_valid(v[0]),
    .mem_inst_access_fault(ff[0]),
    .load_addr(la), .load_data(ld), .load_en(le)
  );

  inst_mem_responder #(
    .DEPTH_WORDS(1024), .BASE_ADDR(32'h0), .WAIT_STATES(3)
  ) dut3 (
    .clk(clk), .reset(reset),
    .mem_fetch_addr(fa), .mem_fetch_addr_en(en),
    .mem_inst_in(dd[1]), .mem_inst_valid(v[1]),
    .mem_inst_access_fault(ff[1]),
    .load_addr(la), .load_data(ld), .load_en(le)
  );

  inst_mem_responder #(
    .DEPTH_WORDS(1024), .BASE_ADDR(32'h100), .WAIT_STATES(0)
  ) dutb (
    .clk(clk), .reset(reset),
    .mem_fetch_addr(fa), .mem_fetch_addr_en(en),
    .mem_inst_in(dd[2]), .mem_inst_valid(v[2]),
    .mem_inst_access_fault(ff[2]),
    .load_addr(la), .load_data(ld), .load_en(le)
  );

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic load_word(input logic [31:0] a, input logic [31:0] d);
    la = a;
    ld = d;
    le = 1'b1;
    @(negedge clk);
    le = 1'b0;
  endtask

  task automatic idle();
    en = 1'b0;
    @(negedge clk);
  endtask

  task automatic push(input int sel, input logic [31:0] d,
                      input logic f, input int lat);
    exp_t e;
    e.sel = sel;
    e.data = d;
    e.fault = f;
    e.lat = lat;
    q.push_back(e);
  endtask

  task automatic wait_resp();
    exp_t e;
    int k;
    if (q.size() == 0) begin
      chk("scoreboard_nonempty", 0, 1);
      return;
    end
    e = q.pop_front();
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!v[e.sel] && k < e.lat + 8);
    chk($sformatf("lat%0d", e.sel), k, e.lat);
    chk($sformatf("valid%0d", e.sel), v[e.sel], 1);
    chk($sformatf("data%0d", e.sel), dd[e.sel], e.data);
    chk($sformatf("fault%0d", e.sel), ff[e.sel], e.fault);
  endtask

  task automatic fetch(input int sel, input logic [31:0] a,
                       input logic [31:0] d, input logic f,
                       input int lat);
    fa = a;
    en = 1'b1;
    push(sel, d, f, lat);
    wait_resp();
  endtask

  initial begin
    logic [31:0] prog [4];
    int t_prev;
    prog[0] = 32'h0000_0013;
    prog[1] = 32'h0010_0093;
    prog[2] = 32'h0020_0113;
    prog[3] = 32'h0030_0193;

    @(negedge clk);
    chk("rst_valid", {v[1], v[0]}, 0);
    chk("rst_data0", dd[0], 0);
    chk("rst_fault", {ff[1], ff[0]}, 0);
    reset = 1'b0;
    @(negedge clk);
    chk("post_rst_valid", v, 0);
    chk("post_rst_data", dd[0], 0);

    for (int i = 0; i < 4; i++) load_word(32'(4 * i), prog[i]);
    load_word(32'h10, 32'h0040_0213);
    load_word(32'hFFC, 32'h1234_5678);
    load_word(32'h100, 32'hCAFE_F00D);
    idle();

    // sequential W=0 stream: one word every two cycles
    t_prev = 0;
    for (int i = 0; i < 4; i++) begin
      fetch(0, 32'(4 * i), prog[i], 1'b0, 1);
      if (i > 0) chk("seq_spacing", cyc - t_prev, 2);
      t_prev = cyc;
      @(negedge clk);
      chk("seq_hold_valid", v[0], 1);
    end

    idle();
    fetch(1, 32'h8, 32'h0020_0113, 1'b0, 4);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("hold3", {v[1], dd[1]}, {1'b1, 32'h0020_0113});
    end

    // redirect during WAIT aborts to IDLE, then recaptures
    idle();
    fa = 32'h4;
    en = 1'b1;
    @(negedge clk);
    chk("redir_no_valid", v[1], 0);
    fa = 32'h10;
    push(1, 32'h0040_0213, 1'b0, 5);
    wait_resp();

    idle();
    fetch(0, 32'h1000, 32'h0, 1'b1, 1);
    idle();
    fetch(0, 32'hFFFF_FFFC, 32'h0, 1'b1, 1);
    idle();
    fetch(2, 32'hFC, 32'h0, 1'b1, 1);
    idle();
    fetch(2, 32'h100, 32'hCAFE_F00D, 1'b0, 1);
    idle();
    fetch(0, 32'hFFC, 32'h1234_5678, 1'b0, 1);

    // load while responding cancels the held response
    idle();
    fetch(0, 32'h8, 32'h0020_0113, 1'b0, 1);
    la = 32'h8;
    ld = 32'hDEAD_BEEF;
    le = 1'b1;
    #1;
    chk("load_cancel_valid", v[0], 0);
    @(negedge clk);
    le = 1'b0;
    push(0, 32'hDEAD_BEEF, 1'b0, 1);
    wait_resp();

    idle();
    fa = 32'hC;
    en = 1'b1;
    la = 32'hC;
    ld = 32'h0BAD_C0DE;
    le = 1'b1;
    @(negedge clk);
    chk("load_wins_valid", v[0], 0);
    le = 1'b0;
    push(0, 32'h0BAD_C0DE, 1'b0, 1);
    wait_resp();

    // reset in WAIT (dut3) and RESPOND (dut0)
    idle();
    fa = 32'h8;
    en = 1'b1;
    @(negedge clk);
    chk("pre_rst_resp0", v[0], 1);
    reset = 1'b1;
    #1;
    chk("rst_wait_valid", v[1], 0);
    chk("rst_wait_data", dd[1], 0);
    chk("rst_wait_fault", ff[1], 0);
    chk("rst_resp_valid", v[0], 0);
    chk("rst_resp_data", dd[0], 0);
    @(negedge clk);
    reset = 1'b0;
    push(1, 32'hDEAD_BEEF, 1'b0, 4);
    wait_resp();

    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("rst_resp2_valid", v[0], 0);
    chk("rst_resp2_data", dd[0], 0);
    @(negedge clk);
    reset = 1'b0;
    push(0, 32'hDEAD_BEEF, 1'b0, 1);
    wait_resp();

    idle();
    chk("queue_empty", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
